pipe_regfile: RTL
=================

PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter NUM_READ, default 2, number of independent read ports (1..4).
REQ-002 SHALL have parameter NUM_WRITE, default 2, number of write ports (1..2).
REQ-003 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-004 Port clk  in  1  single clock; all state updates on posedge clk.
REQ-005 Port reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 Port rd_id  in  NUM_READ x reg_id_t  read register selectors.
REQ-007 Port rd_data  out  NUM_READ x op_t  read values.
REQ-008 Port rd_busy  out  NUM_READ x 1  selected register awaits a pending write.
REQ-009 Port we  in  NUM_WRITE x 1  write enables.
REQ-010 Port wr_id  in  NUM_WRITE x reg_id_t  write destinations.
REQ-011 Port wr_data  in  NUM_WRITE x op_t  write values.
REQ-012 Port claim  in  1  reserve a destination (instruction issue).
REQ-013 Port claim_id  in  reg_id_t  register being reserved.
REQ-014 Port claim_ok  out  1  combinational: claim accepted this cycle.

Function
REQ-015 Storage SHALL be 32 x op_t; register 0 SHALL always read 0, ignore writes, never be busy.
REQ-016 Reads SHALL be combinational; rd_data[i] = regs[rd_id[i]] when no forwarding applies.
REQ-017 With BYPASS=1, if we[j] and wr_id[j]==rd_id[i]!=0 this cycle, rd_data[i] SHALL be wr_data[j]; highest matching j wins.
REQ-018 With BYPASS=0, rd_data SHALL reflect only state at the preceding posedge.
REQ-019 On posedge, each we[j] with wr_id[j]!=0 SHALL write wr_data[j]; on equal wr_id, highest j wins.
REQ-020 Each busy bit SHALL be set on posedge when claim && claim_ok for that id, and cleared on posedge when any we[j] targets it.
REQ-021 Simultaneous claim and write to same id SHALL leave busy=1 (new owner) and still write data.
REQ-022 claim_ok SHALL be claim && (claim_id==0 || !busy[claim_id] || any we[j] targets claim_id this cycle); claim of id 0 SHALL be accepted with no effect.
REQ-023 rd_busy[i] SHALL be busy[rd_id[i]], masked to 0 when BYPASS=1 and a write to rd_id[i] occurs this cycle.
REQ-024 A write to a non-busy register SHALL be legal and SHALL write normally.
REQ-025 Latency: write-to-read 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.

Reset
REQ-026 While reset is high at posedge, all registers SHALL become 0 except reg 28 = GPAt and reg 29 = SPAt; all busy bits SHALL clear.
REQ-027 Reset SHALL override any write or claim in the same cycle; bypass forwarding SHALL still apply combinationally during reset.
REQ-028 Outputs after reset: rd_data per initial values, rd_busy all 0, claim_ok = claim.

Structure
REQ-029 reg_id_t, op_t, GPAt, SPAt SHALL come from the shared Types/Parameters packages; NUM_REGS=32 SHALL be added to Parameters.
REQ-030 Busy tracking SHALL be a sub-module reg_scoreboard (busy vector, set/clear, claim_ok logic).

Verification
REQ-031 Reset then rd_id={28,29} -> rd_data={GPAt,SPAt}, rd_busy={0,0}.
REQ-032 we[0]=1,wr_id[0]=5,wr_data=32'hDEAD_BEEF, rd_id[0]=5, BYPASS=1 -> same-cycle rd_data[0]=32'hDEAD_BEEF; BYPASS=0 -> old value, new next cycle.
REQ-033 Both ports write id 7 (32'h1111, 32'h2222) -> reg 7 = 32'h2222; write id 0 -> reads 0.
REQ-034 claim id 9 -> busy; second claim id 9 -> claim_ok=0; write id 9 -> busy cleared next cycle.
REQ-035 claim id 9 with concurrent write id 9 while busy -> claim_ok=1, data written, busy stays 1.
REQ-036 reset asserted during write id 28 with 32'h0 -> reg 28 = GPAt, all busy 0.

Source files
------------

// File: rtl/pipe_regfile_pkg.sv
// pipe_regfile_pkg
// Shared types and constants for the pipelined register file.
//   reg_id_t : architectural register selector (5 bits, 32 registers)
//   op_t     : operand / register value (32 bits)
//   GPAT     : reset value of the global pointer register (r28)
//   SPAT     : reset value of the stack pointer register (r29)
//   NUM_REGS : number of architectural registers
package pipe_regfile_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_ID_W  = $clog2(NUM_REGS);
    localparam int OP_W      = 32;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [OP_W-1:0]     op_t;

    localparam reg_id_t GP_ID = reg_id_t'(28);
    localparam reg_id_t SP_ID = reg_id_t'(29);

    localparam op_t GPAT = 32'h1000_8000;
    localparam op_t SPAT = 32'h7FFF_FFF0;

    // True when a write port is actually updating architectural state
    // (register 0 is hard-wired to zero and never written).
    function automatic logic is_real_write(input logic en, input reg_id_t id);
        return en && (id != '0);
    endfunction

endpackage

// File: rtl/pipe_regfile_reg_scoreboard.sv
// reg_scoreboard
// Tracks which registers have an outstanding (claimed, not yet written)
// result. A claim reserves a destination; any write to that destination
// releases it. A claim that coincides with the releasing write is granted
// and hands the register to the new owner.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   claim, claim_id   : reservation request and its destination
//   claim_ok          : combinational grant for the current request
//   we, wr_id         : write-port enables and destinations
//   busy              : per-register pending-write flags (bit 0 always 0)
//   wr_hit            : per-register "some write port targets it this cycle"
module reg_scoreboard
    import pipe_regfile_pkg::*;
#(
    parameter int NUM_WRITE = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          claim,
    input  reg_id_t                       claim_id,
    output logic                          claim_ok,
    input  logic    [NUM_WRITE-1:0]       we,
    input  reg_id_t [NUM_WRITE-1:0]       wr_id,
    output logic    [NUM_REGS-1:0]        busy,
    output logic    [NUM_REGS-1:0]        wr_hit
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    // Decode every write port onto the register space.
    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (is_real_write(we[j], wr_id[j])) begin
                wr_hit[wr_id[j]] = 1'b1;
            end
        end
    end

    // A register can be claimed when it is free or is being released by a
    // write in this very cycle. Register 0 is always grantable and is never
    // marked busy.
    always_comb begin
        claim_ok = claim && ((claim_id == '0) || !busy_reg[claim_id] || wr_hit[claim_id]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                // Setting wins over clearing so a same-cycle claim + write
                // leaves the register owned by the newly issued instruction.
                assign busy_next[gi] = (busy_reg[gi] && !wr_hit[gi]) ||
                                       (claim_ok && (claim_id == reg_id_t'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile
// 32-entry register file with combinational multi-port read, multi-port
// write, optional same-cycle write-to-read forwarding and a scoreboard of
// pending destinations.
// Parameters:
//   NUM_READ  : number of read ports (1..4)
//   NUM_WRITE : number of write ports (1..2)
//   BYPASS    : 1 = forward this cycle's write data to readers
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rd_id / rd_data     : read selectors and values
//   rd_busy             : selected register still awaits a pending write
//   we / wr_id / wr_data: write ports (highest index wins on conflicts)
//   claim / claim_id    : destination reservation at instruction issue
//   claim_ok            : combinational grant of the reservation
module pipe_regfile
    import pipe_regfile_pkg::*;
#(
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  reg_id_t [NUM_READ-1:0]   rd_id,
    output op_t     [NUM_READ-1:0]   rd_data,
    output logic    [NUM_READ-1:0]   rd_busy,
    input  logic    [NUM_WRITE-1:0]  we,
    input  reg_id_t [NUM_WRITE-1:0]  wr_id,
    input  op_t     [NUM_WRITE-1:0]  wr_data,
    input  logic                     claim,
    input  reg_id_t                  claim_id,
    output logic                     claim_ok
);

    op_t regs_reg  [NUM_REGS];
    op_t regs_next [NUM_REGS];

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wr_hit;

    reg_scoreboard #(
        .NUM_WRITE (NUM_WRITE)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .claim    (claim),
        .claim_id (claim_id),
        .claim_ok (claim_ok),
        .we       (we),
        .wr_id    (wr_id),
        .busy     (busy),
        .wr_hit   (wr_hit)
    );

    // Ascending port order lets the highest-numbered port win when two
    // ports target the same register.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_next[r] = regs_reg[r];
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (is_real_write(we[j], wr_id[j])) begin
                regs_next[wr_id[j]] = wr_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_reg[r] <= '0;
            end
            regs_reg[GP_ID] <= GPAT;
            regs_reg[SP_ID] <= SPAT;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_reg[r] <= regs_next[r];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            op_t  data_next;
            logic fwd_hit;

            always_comb begin
                data_next = regs_reg[rd_id[gi]];
                fwd_hit   = 1'b0;
                if (BYPASS) begin
                    for (int j = 0; j < NUM_WRITE; j++) begin
                        if (is_real_write(we[j], wr_id[j]) && (wr_id[j] == rd_id[gi])) begin
                            data_next = wr_data[j];
                            fwd_hit   = 1'b1;
                        end
                    end
                end
            end

            // Register 0 storage is never written, so it stays zero; the
            // explicit mask keeps the zero guarantee independent of storage.
            assign rd_data[gi] = (rd_id[gi] == '0) ? '0 : data_next;
            // A forwarded value is already the awaited result, so it is not busy.
            assign rd_busy[gi] = busy[rd_id[gi]] && !fwd_hit;
        end
    endgenerate

endmodule
